// File: rtl/posit_multiplier.sv
// Posit multiplier: decodes two N-bit posits (es = ES), multiplies them and
// re-encodes the product with round-to-nearest-even and saturation to
// minpos/maxpos. The output register is the only state in the block.
module posit_multiplier #(
  parameter int N  = 32,
  parameter int ES = 4,
  parameter int RS = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic [N-1:0] OUT
);

  localparam int FW = N - 1 - ES;          // fraction bits of a decoded operand
  localparam int MW = FW + 1;              // mantissa with hidden one
  localparam int PW = 2 * MW;              // full mantissa product
  localparam int SW = RS + ES + 3;         // signed scale width
  localparam int YW = 2 + ES + (PW - 1) + N; // encode shifter width

  localparam logic [N-1:0]         NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]         MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]         MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-2:0]         ONE_B  = {{(N-2){1'b0}}, 1'b1};
  localparam logic [RS:0]          ONE_RS = {{RS{1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] ONE_S  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] ZERO_S = {SW{1'b0}};
  localparam logic signed [SW-1:0] K_MAX  = SW'(N - 2);
  localparam logic signed [SW-1:0] K_MIN  = SW'(-(N - 1));

  logic [N-1:0] out_d;
  logic [N-1:0] out_q;

  // Length of the leading run of bits equal to the first bit of the body.
  function automatic logic [RS-1:0] run_len(input logic [N-2:0] body);
    logic          done;
    logic [RS-1:0] m;
    m    = '0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done && (body[i] == body[N-2])) begin
        m = m + {{(RS-1){1'b0}}, 1'b1};
      end else begin
        done = 1'b1;
      end
    end
    return m;
  endfunction

  // Split a posit into sign, scale (k*2^ES + e) and mantissa with hidden one.
  function automatic void decode(input  logic [N-1:0]         x,
                                 output logic                 sgn,
                                 output logic signed [SW-1:0] scale,
                                 output logic [MW-1:0]        mant);
    logic [N-2:0]         body;
    logic [N-2:0]         rem;
    logic [RS-1:0]        m;
    logic signed [SW-1:0] km;
    logic signed [SW-1:0] k;
    logic [ES-1:0]        e;
    sgn   = x[N-1];
    // low bits of the two's complement only depend on the low bits
    body  = x[N-1] ? (~x[N-2:0] + ONE_B) : x[N-2:0];
    m     = run_len(body);
    // drop the regime run and its terminator; vacated bits read as zero
    rem   = body << ({1'b0, m} + ONE_RS);
    e     = rem[N-2 -: ES];
    km    = $signed({{(SW-RS){1'b0}}, m});
    k     = body[N-2] ? (km - ONE_S) : -km;
    scale = (k <<< ES) + $signed({{(SW-ES){1'b0}}, e});
    mant  = {1'b1, rem[FW-1:0]};
  endfunction

  // Combinational decode / multiply / normalise / encode / round.
  always_comb begin
    logic                 sa, sb, s_o;
    logic signed [SW-1:0] sc_a, sc_b, sc_o, k_o, sh;
    logic [MW-1:0]        ma, mb;
    logic [PW-1:0]        prod;
    logic [PW-2:0]        frac_n;
    logic [ES-1:0]        e_o;
    logic [1:0]           seed;
    logic signed [YW-1:0] y;
    logic [N-2:0]         body_o;
    logic                 guard, sticky, rnd;
    logic [N-1:0]         mag, res;

    out_d = '0;
    decode(IN1, sa, sc_a, ma);
    decode(IN2, sb, sc_b, mb);
    s_o  = sa ^ sb;
    prod = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};

    if (prod[PW-1]) begin
      frac_n = prod[PW-2:0];
      sc_o   = sc_a + sc_b + ONE_S;
    end else begin
      frac_n = {prod[PW-3:0], 1'b0};
      sc_o   = sc_a + sc_b;
    end

    k_o = sc_o >>> ES;
    e_o = sc_o[ES-1:0];

    // seed "10" grows a run of ones, "01" a run of zeros, under arithmetic shift
    if (k_o >= ZERO_S) begin
      seed = 2'b10;
      sh   = k_o;
    end else begin
      seed = 2'b01;
      sh   = -k_o - ONE_S;
    end

    y      = $signed({seed, e_o, frac_n, {N{1'b0}}}) >>> $unsigned(sh);
    body_o = y[YW-1 -: N-1];
    guard  = y[YW-N];
    sticky = |y[YW-N-1:0];
    rnd    = guard & (sticky | body_o[0]);
    mag    = {1'b0, body_o + {{(N-2){1'b0}}, rnd}};

    if (k_o >= K_MAX) begin
      mag = MAXPOS;
    end else if (k_o <= K_MIN) begin
      mag = MINPOS;
    end else begin
      mag = mag;
    end

    res = s_o ? (~mag + MINPOS) : mag;

    if ((IN1 == NAR) || (IN2 == NAR)) begin
      out_d = NAR;
    end else if ((IN1 == '0) || (IN2 == '0)) begin
      out_d = '0;
    end else begin
      out_d = res;
    end
  end

  // Output register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_posit_multiplier.sv
// Directed bench for posit_multiplier (N=32, ES=4). Operands are applied
// back-to-back every cycle and each product is checked one cycle later.
// Random cases use a bit-serial integer reference model of posit<32,4>.
module tb_posit_multiplier;

  logic        clk;
  logic        reset;
  logic [31:0] IN1;
  logic [31:0] IN2;
  logic [31:0] OUT;

  int n_checks;
  int n_fails;

  posit_multiplier #(.N(32), .ES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .IN1   (IN1),
    .IN2   (IN2),
    .OUT   (OUT)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Bit-serial decode: sign, scale and 28-bit mantissa with hidden one.
  function automatic void ref_decode(input logic [31:0] x, output bit s,
                                     output int sc, output logic [27:0] mant);
    logic [31:0] v;
    int          i, m, k, e;
    bit          r0;
    s  = x[31];
    v  = s ? (~x + 32'd1) : x;
    r0 = v[30];
    m  = 0;
    i  = 30;
    while (i >= 0 && v[i] == r0) begin
      m++;
      i--;
    end
    k = r0 ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < 4; j++) begin
      e = e * 2 + ((i >= 0) ? int'(v[i]) : 0);
      i--;
    end
    mant = 28'd1;
    for (int j = 0; j < 27; j++) begin
      mant = {mant[26:0], (i >= 0) ? v[i] : 1'b0};
      i--;
    end
    sc = k * 16 + e;
  endfunction

  // Reference product: exact mantissa product, then the posit bit string is
  // generated one bit at a time and rounded to nearest even.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    bit          sa, sb, s;
    int          sca, scb, sc, e, k, fi;
    logic [27:0] ma, mb;
    logic [55:0] p;
    logic [30:0] body;
    logic [31:0] mag;
    bit          q[$];
    bit          guard, sticky;
    if (a == 32'h80000000 || b == 32'h80000000) return 32'h80000000;
    if (a == 32'h0 || b == 32'h0) return 32'h0;
    ref_decode(a, sa, sca, ma);
    ref_decode(b, sb, scb, mb);
    s  = sa ^ sb;
    p  = {28'd0, ma} * {28'd0, mb};
    sc = sca + scb;
    if (p[55]) begin
      sc++;
      fi = 54;
    end else begin
      fi = 53;
    end
    e = ((sc % 16) + 16) % 16;
    k = (sc - e) / 16;
    if (k >= 30) begin
      mag = 32'h7FFFFFFF;
    end else if (k <= -31) begin
      mag = 32'h00000001;
    end else begin
      if (k >= 0) begin
        for (int j = 0; j <= k; j++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int j = 0; j < -k; j++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int j = 3; j >= 0; j--) q.push_back(e[j]);
      for (int j = fi; j >= 0; j--) q.push_back(p[j]);
      body = '0;
      for (int j = 0; j < 31; j++) body = {body[29:0], q[j]};
      guard  = q[31];
      sticky = 1'b0;
      for (int j = 32; j < q.size(); j++) sticky = sticky | q[j];
      if (guard && (sticky || body[0])) body = body + 31'd1;
      mag = {1'b0, body};
    end
    return s ? (~mag + 32'd1) : mag;
  endfunction

  task automatic check(input string tag, input logic [31:0] expv);
    n_checks++;
    assert (OUT === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, OUT, expv);
    end
  endtask

  // Apply operands just after an edge, check the product just after the next.
  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expv, input string tag);
    IN1 = a;
    IN2 = b;
    @(posedge clk);
    #1;
    check(tag, expv);
  endtask

  initial begin
    logic [31:0] a, b;
    n_checks = 0;
    n_fails  = 0;

    // Reset held with nonzero operands.
    reset = 1'b1;
    IN1   = 32'h7FC00000;
    IN2   = 32'h7FC00000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", 32'h7FFFC000);

    // Reset asserted between edges clears OUT without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("async_reset", 32'h0);
    #1 reset = 1'b0;

    // Specials.
    step(32'h80000000, 32'hA92AA456, 32'h80000000, "nar_a");
    step(32'hA92AA456, 32'h80000000, 32'h80000000, "nar_b");
    step(32'h00000000, 32'h80000000, 32'h80000000, "zero_times_nar");
    step(32'h00000000, 32'h54AAA545, 32'h00000000, "zero_a");
    step(32'h4954A722, 32'h00000000, 32'h00000000, "zero_b");

    // Large squares and mixed signs.
    step(32'h7FC00000, 32'h7FC00000, 32'h7FFFC000, "sq_pos");
    step(32'h80400000, 32'h80400000, 32'h7FFFC000, "sq_neg");
    step(32'h7FC00000, 32'h80400000, 32'h80004000, "mixed");
    step(32'h7FFFC000, 32'h80004000, 32'h80000001, "neg_overflow");

    // Small exact values.
    step(32'h41000000, 32'h41000000, 32'h42400000, "1p5_sq");
    step(32'h42000000, 32'h3E000000, 32'h40000000, "two_times_half");
    step(32'hC0000000, 32'h40000000, 32'hC0000000, "minus_one");

    // Rounding: tie to even up, tie to even down, above half.
    step(32'h40000001, 32'h41000000, 32'h41000002, "tie_up");
    step(32'h40000003, 32'h41000000, 32'h41000004, "tie_down");
    step(32'h40000001, 32'h41000001, 32'h41000003, "above_half");
    step(32'h40000002, 32'h40000002, 32'h40000004, "below_half");

    // Saturation.
    step(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, "maxpos_sq");
    step(32'h00000001, 32'h00000001, 32'h00000001, "minpos_sq");
    step(32'h7FFFFFFF, 32'h42000000, 32'h7FFFFFFF, "maxpos_x2");
    step(32'h00000001, 32'h3E000000, 32'h00000001, "minpos_half");
    step(32'h80000001, 32'h7FFFFFFF, 32'h80000001, "neg_maxpos_sq");

    // Unity: 1.0 * X == X.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      if (i % 2 == 0) step(32'h40000000, a, a, $sformatf("unity_l%0d", i));
      else            step(a, 32'h40000000, a, $sformatf("unity_r%0d", i));
    end

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i < 20) begin
        a[30] = ~a[29];
        b[30] = ~b[29];
      end
      step(a, b, ref_mul(a, b), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
